uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver. Next generation of the team's fixed 8N1 receiver.
//  Adds: runtime baud divisor; configurable data bits, parity and stop bits.
//  Adds: start-bit glitch rejection, and framing/parity/overrun flags.
//  Break detection holds off re-arming until the line returns high.
//  Sits between the off-chip RX pin and a host register/FIFO interface.
// PARAMETERS
//  DATA_BITS  8   payload bits per frame, 5..9, sent LSB first
//  STOP_BITS  1   stop bits checked, 1 or 2
//  DIV_W      16  width of baud_div
// PORTS
//  clk          in   1          system clock; single clock domain
//  rst          in   1          reset; synchronous, active-high
//  RX           in   1          asynchronous serial line, idle high
//  baud_div     in   DIV_W      clocks per bit; captured when a start edge is detected
//  parity_mode  in   2          00 none, 01 even, 10 odd, 11 treated as none; captured with baud_div
//  clr_rdy      in   1          host acknowledge; clears rdy, parity_err, frame_err, overrun
//  rx_data      out  DATA_BITS  last received payload
//  rdy          out  1          frame available
//  parity_err   out  1          parity mismatch on the frame in rx_data
//  frame_err    out  1          a stop bit was sampled low on the frame in rx_data
//  overrun      out  1          a frame completed while rdy=1 (sticky)
// BEHAVIOUR
//  - Reset: state=IDLE; synchroniser flops=1; rx_data=0; all flags=0. Reset mid-frame aborts silently.
//  - RX passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
//  - Divisor: eff_div = max(baud_div, 4). Half period = eff_div>>1.
//    Down-counter; a bit is sampled when the count reaches 0, then the count reloads eff_div-1.
//  - IDLE: rx_s==0 -> capture baud_div and parity_mode; load half-1; go to START.
//  - START: at the sample point, rx_s==1 -> glitch; back to IDLE with no flag change.
//    Otherwise go to DATA with bit_cnt=0.
//  - DATA: shift rx_s in at the MSB (right shift), DATA_BITS samples.
//    Then go to PARITY if parity is enabled, else to STOP.
//  - PARITY: sample one bit. even: err = ^{data,bit}; odd: err = ~^{data,bit}.
//  - STOP: STOP_BITS samples; frame_err_int |= ~rx_s. After the last sample:
//    - rx_data updates on the following cycle (latency = 1 clk after the last stop-bit mid-sample).
//    - rdy=1; parity_err and frame_err are loaded with this frame's results.
//    - Next state: to BREAK if frame_err_int, else to IDLE.
//  - BREAK: wait for rx_s==1, then go to IDLE. No start detection occurs in BREAK.
//  - Overrun: if the frame-complete cycle finds rdy==1 and clr_rdy==0, set overrun.
//    rx_data and the error flags are still overwritten with the new frame.
//  - clr_rdy and frame-complete in the same cycle: completion wins.
//    rdy=1, new flags loaded, overrun not set.
//  - clr_rdy while idle with rdy=0: no effect. Flags never self-clear.
//  - baud_div/parity_mode changes mid-frame have no effect until the next start.
// STRUCTURE
//  - Shared package uart_pkg: parity_mode_t (PAR_NONE, PAR_EVEN, PAR_ODD).
//  - uart_pkg also holds rx_state_t (IDLE, START, DATA, PARITY, STOP, BREAK).
//  - uart_pkg also holds constant UART_MIN_DIV=4; the transmitter will reuse the package.
//  - One sub-module, uart_bit_timer (down-counter with load_half/load_full, out tick).
//    The transmitter will reuse uart_bit_timer.
//  - The FSM, shift register, bit counter and flag flops live in this module.
// TESTING
//  1. baud_div=16, parity none, send 0xA5 8N1 -> one cycle after the stop mid-sample,
//     rdy=1, rx_data=0xA5, all errors 0.
//  2. parity even, send 0x3C with parity bit 1 -> rdy=1, rx_data=0x3C, parity_err=1.
//     Then pulse clr_rdy -> rdy=0 and parity_err=0.
//  3. baud_div=16, RX low for 5 clks then high -> START rejects it; back to IDLE.
//     rdy stays 0 and a following 0x55 frame is received correctly.
//  4. RX held low for 12 bit times -> frame_err=1, rx_data=0x00, module in BREAK.
//     No second rdy until RX returns high; a following 0x81 frame is then received.
//  5. Two frames 0x11 then 0x22 without clr_rdy -> overrun=1, rx_data=0x22.
//     Also: clr_rdy on the completion cycle of a frame -> rdy stays 1, overrun=0.
//  6. rst pulsed mid-DATA of 0xF0 -> outputs 0 next cycle. baud_div=3 (clamped to 4),
//     DATA_BITS=7, STOP_BITS=2, odd parity -> 0x5A received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose : Shared definitions for the UART receiver and transmitter.
//           Holds the parity mode and receiver state enums, the minimum
//           divisor, and a helper that maps the raw parity_mode field
//           onto parity_mode_t.
// Ports   : none (package)
package uart_pkg;

   // Smallest usable divisor. The mid-bit sample point needs a half period
   // of at least 2 clocks.
   localparam int UART_MIN_DIV = 4;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_mode_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   // The encoding 2'b11 is reserved and behaves like "no parity".
   function automatic parity_mode_t decode_parity(input logic [1:0] mode);
      parity_mode_t result;
      case (mode)
         2'b01:   result = PAR_EVEN;
         2'b10:   result = PAR_ODD;
         default: result = PAR_NONE;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Purpose : Bit-period down-counter shared by the UART receiver and
//           transmitter. load_half starts a half period (used to land on
//           the middle of the start bit), load_full starts a full period.
//           While run is high the counter auto-reloads div-1 each time it
//           reaches zero, and tick is high for that one cycle.
// Ports   : clk, rst      clock, synchronous active-high reset
//           load_half     load (div>>1)-1
//           load_full     load div-1
//           run           count enable
//           div           effective clocks per bit (already clamped)
//           tick          count reached zero while running
module uart_bit_timer #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_half,
   input  logic             load_full,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load_half) begin
         cnt <= (div >> 1) - DIV_W'(1);
      end else if (load_full) begin
         cnt <= div - DIV_W'(1);
      end else if (run) begin
         if (cnt == '0) begin
            cnt <= div - DIV_W'(1);
         end else begin
            cnt <= cnt - DIV_W'(1);
         end
      end
   end

   assign tick = run && (cnt == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// Purpose : Configurable UART receiver. Runtime baud divisor and parity
//           mode (captured on each start edge), DATA_BITS payload bits LSB
//           first, STOP_BITS checked stop bits, start-bit glitch rejection,
//           parity/framing/overrun flags and break hold-off.
// Ports   : clk, rst      clock, synchronous active-high reset
//           RX            asynchronous serial line, idle high
//           baud_div      clocks per bit (values below 4 act as 4)
//           parity_mode   00 none, 01 even, 10 odd, 11 none
//           clr_rdy       host acknowledge; clears rdy and all flags
//           rx_data       last received payload
//           rdy           frame available
//           parity_err    parity mismatch on the frame in rx_data
//           frame_err     a stop bit was sampled low on that frame
//           overrun       a frame completed while rdy was still set
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RX,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 clr_rdy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdy,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   rx_state_t              state;
   parity_mode_t           par_q;
   logic                   rx_meta;
   logic                   rx_s;
   logic [DIV_W-1:0]       div_q;
   logic [DIV_W-1:0]       eff_in;
   logic [DIV_W-1:0]       timer_div;
   logic [DATA_BITS-1:0]   shift;
   logic [3:0]             bit_cnt;
   logic                   par_err_int;
   logic                   frame_err_int;
   logic                   start_det;
   logic                   timer_run;
   logic                   tick;
   logic                   stop_bad;

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   assign eff_in    = (baud_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : baud_div;
   assign start_det = (state == IDLE) && !rx_s;
   // The half-period load happens in the same cycle the divisor is captured,
   // so the timer sees the live clamped input then and the captured copy after.
   assign timer_div = start_det ? eff_in : div_q;
   assign timer_run = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);
   assign stop_bad  = frame_err_int | ~rx_s;

   uart_bit_timer #(
      .DIV_W(DIV_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_half(start_det),
      .load_full(1'b0),
      .run      (timer_run),
      .div      (timer_div),
      .tick     (tick)
   );

   // Receive FSM plus datapath and host flags. A clr_rdy is applied first so
   // that a frame completing in the same cycle overrides it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         par_q         <= PAR_NONE;
         div_q         <= DIV_W'(UART_MIN_DIV);
         shift         <= '0;
         bit_cnt       <= '0;
         par_err_int   <= 1'b0;
         frame_err_int <= 1'b0;
         rx_data       <= '0;
         rdy           <= 1'b0;
         parity_err    <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (clr_rdy) begin
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  div_q         <= eff_in;
                  par_q         <= decode_parity(parity_mode);
                  par_err_int   <= 1'b0;
                  frame_err_int <= 1'b0;
                  bit_cnt       <= '0;
                  state         <= START;
               end
            end
            START: begin
               if (tick) begin
                  // Line back high at mid start bit: treat as noise.
                  state   <= rx_s ? IDLE : DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (tick) begin
                  shift <= {rx_s, shift[DATA_BITS-1:1]};
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= (par_q == PAR_NONE) ? STOP : PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  par_err_int <= (par_q == PAR_EVEN) ? (^{shift, rx_s}) : ~(^{shift, rx_s});
                  state       <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (bit_cnt == LAST_STOP) begin
                     rx_data    <= shift;
                     rdy        <= 1'b1;
                     parity_err <= par_err_int;
                     frame_err  <= stop_bad;
                     overrun    <= clr_rdy ? 1'b0 : (overrun | rdy);
                     bit_cnt    <= '0;
                     state      <= stop_bad ? BREAK : IDLE;
                  end else begin
                     frame_err_int <= stop_bad;
                     bit_cnt       <= bit_cnt + 4'd1;
                  end
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
